// File: rtl/rgbw_frame_sender.sv
// rgbw_frame_sender: SPI-master (mode 0, MSB first) transmitter for the RGBW lamp link.
// On start (sampled only when idle) snapshots the seven parameter bytes, prefixes SYNC_BYTE,
// and shifts out one 8-byte frame with cs_n held low throughout. sclk idles low between
// bytes for GAP_CYCLES so the slave can recover.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-low
//   start      request one frame
//   lint, color_idx, red, green, blue, white, mode   frame bytes 1..7
//   busy       high from the cycle after start is accepted until the done cycle (exclusive)
//   done       one-cycle pulse at frame end
//   spi_sclk, spi_mosi, spi_cs_n   registered SPI outputs
module rgbw_frame_sender #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8,
  parameter logic [7:0]  SYNC_BYTE  = 8'h55
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] lint,
  input  logic [7:0] color_idx,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic [7:0] white,
  input  logic [7:0] mode,
  output logic       busy,
  output logic       done,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n
);

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StGap, StHold} state_e;

  state_e      st_q, st_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic [63:0] frame_q, frame_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // {byte, bit} forms a 6-bit stream position; frame bit 63 goes out first, so the
  // vector position of stream index i is ~i.
  logic [5:0]  idx_n;
  logic [5:0]  pos_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q    <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      frame_q <= frame_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    frame_d = frame_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    idx_n   = {byte_q, bit_q} + 6'd1;
    pos_n   = ~idx_n;

    unique case (st_q)
      StIdle: begin
        busy_d = 1'b0;
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (start) begin
          frame_d = {SYNC_BYTE, lint, color_idx, red, green, blue, white, mode};
          st_d    = StSetup;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = SYNC_BYTE[7];
        end
      end
      StSetup: begin
        if (cnt_q == DivLast) begin
          st_d   = StHigh;
          cnt_d  = '0;
          sclk_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHigh: begin
        if (cnt_q == DivLast) begin
          cnt_d            = '0;
          sclk_d           = 1'b0;
          {byte_d, bit_d}  = idx_n;  // bit index wraps 7->0 as the byte index advances
          if (bit_q != 3'd7) begin
            st_d   = StLow;
            mosi_d = frame_q[pos_n];
          end else if (byte_q != 3'd7) begin
            st_d   = StGap;
            mosi_d = frame_q[pos_n];
          end else begin
            st_d   = StHold;
            mosi_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StLow: begin
        if (cnt_q == DivLast) begin
          st_d   = StHigh;
          cnt_d  = '0;
          sclk_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          st_d   = StHigh;
          cnt_d  = '0;
          sclk_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (cnt_q == DivLast) begin
          st_d   = StIdle;
          cnt_d  = '0;
          cs_n_d = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_rgbw_frame_sender.sv
// Bench for rgbw_frame_sender: two instances (default timing and CLK_DIV=1/GAP_CYCLES=1)
// share a clock and data inputs. An SPI slave model per instance rebuilds bytes on sclk
// rises and pops expected bytes from a scoreboard queue filled when start is driven.
module tb_rgbw_frame_sender;

  localparam int unsigned DivA = 4;
  localparam int unsigned GapA = 8;
  localparam int unsigned DivB = 1;
  localparam int unsigned GapB = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] lint = '0, color_idx = '0, red = '0, green = '0, blue = '0, white = '0, mode = '0;
  logic [1:0] busy, done, sclk, mosi, cs_n;

  always #5 clk = ~clk;

  rgbw_frame_sender #(.CLK_DIV(DivA), .GAP_CYCLES(GapA), .SYNC_BYTE(8'h55)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .lint(lint), .color_idx(color_idx),
    .red(red), .green(green), .blue(blue), .white(white), .mode(mode),
    .busy(busy[0]), .done(done[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_cs_n(cs_n[0])
  );

  rgbw_frame_sender #(.CLK_DIV(DivB), .GAP_CYCLES(GapB), .SYNC_BYTE(8'h55)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .lint(lint), .color_idx(color_idx),
    .red(red), .green(green), .blue(blue), .white(white), .mode(mode),
    .busy(busy[1]), .done(done[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_cs_n(cs_n[1])
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  logic [7:0]  exp_q0[$];
  logic [7:0]  exp_q1[$];
  int          rises[2];
  int          nbits[2];
  int          stab[2];
  int          done_n[2];
  int unsigned done_cyc[2];
  logic [7:0]  shreg[2];
  logic        prev_sclk[2];
  logic        prev_mosi[2];

  typedef struct {
    logic [55:0] data;
    bit          poke;
    int unsigned lat_a;
    int unsigned lat_b;
  } vec_t;
  vec_t vecs[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rises[d] = 0; nbits[d] = 0; stab[d] = 0; done_n[d] = 0; done_cyc[d] = 0;
      shreg[d] = '0; prev_sclk[d] = 1'b0; prev_mosi[d] = 1'b0;
    end
  end

  // SPI slave model + protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        nbits[d] = 0;
        shreg[d] = '0;
        stab[d]  = 0;
      end else begin
        if (mosi[d] !== prev_mosi[d]) begin
          chk($sformatf("mosi_change_sclk_low_%0d", d), 64'(sclk[d]), 64'd0);
          stab[d] = 0;
        end else begin
          stab[d]++;
        end
        if (sclk[d] && !prev_sclk[d]) begin
          rises[d]++;
          chk($sformatf("cs_low_at_rise_%0d", d), 64'(cs_n[d]), 64'd0);
          chk($sformatf("mosi_setup_%0d", d),
              64'(stab[d] >= int'((d == 0) ? DivA : DivB)), 64'd1);
          shreg[d] = {shreg[d][6:0], mosi[d]};
          nbits[d]++;
          if (nbits[d] % 8 == 0) begin
            int sz;
            logic [7:0] e;
            sz = (d == 0) ? exp_q0.size() : exp_q1.size();
            chk($sformatf("byte_expected_%0d", d), 64'(sz != 0), 64'd1);
            if (sz != 0) begin
              if (d == 0) e = exp_q0.pop_front();
              else e = exp_q1.pop_front();
              chk($sformatf("byte_%0d", d), 64'(shreg[d]), 64'(e));
            end
          end
        end
        if (done[d]) begin
          done_n[d]++;
          done_cyc[d] = cyc;
        end
      end
      prev_sclk[d] = sclk[d];
      prev_mosi[d] = mosi[d];
    end
  end

  task automatic push_frame(input int d, input logic [55:0] data);
    logic [7:0] b;
    if (d == 0) exp_q0.push_back(8'h55); else exp_q1.push_back(8'h55);
    for (int i = 6; i >= 0; i--) begin
      b = data[i*8 +: 8];
      if (d == 0) exp_q0.push_back(b); else exp_q1.push_back(b);
    end
  endtask

  // Drives start for one cycle, returns the cycle number of the accepting edge, then
  // scrambles the data inputs to show the frame uses the snapshot.
  task automatic start_frame(input logic [55:0] data, input bit use_b, output int unsigned t0);
    @(negedge clk);
    {lint, color_idx, red, green, blue, white, mode} = data;
    push_frame(0, data);
    if (use_b) push_frame(1, data);
    start_a = 1'b1;
    start_b = use_b;
    @(posedge clk);
    #1;
    t0 = cyc;
    start_a = 1'b0;
    start_b = 1'b0;
    {lint, color_idx, red, green, blue, white, mode} = ~data;
    chk("busy_after_accept", 64'(busy[0]), 64'd1);
    chk("cs_low_after_accept", 64'(cs_n[0]), 64'd0);
    chk("mosi_sync_msb", 64'(mosi[0]), 64'd0);
  endtask

  task automatic wait_done(input int d, input int base, input int unsigned t0,
                           input int unsigned lat, input string name);
    for (int i = 0; i < 3000 && done_n[d] == base; i++) begin
      @(negedge clk);
      #1;
    end
    chk({name, "_done_seen"}, 64'(done_n[d] - base), 64'd1);
    chk({name, "_latency"}, 64'(done_cyc[d] - t0), 64'(lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned t0, t1;
    int base0, base1;

    vecs[0] = '{data: {8'h80, 8'h01, 8'hFF, 8'h00, 8'hA5, 8'h3C, 8'h02}, poke: 1'b0,
                lat_a: 544, lat_b: 129};
    vecs[1] = '{data: {8'h00, 8'hFF, 8'h00, 8'hFF, 8'h5A, 8'hC3, 8'h81}, poke: 1'b1,
                lat_a: 544, lat_b: 129};
    vecs[2] = '{data: {8'h7E, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC}, poke: 1'b0,
                lat_a: 544, lat_b: 129};

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_outputs_%0d", d),
          64'({busy[d], done[d], sclk[d], mosi[d], cs_n[d]}), 64'b00001);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 64'({busy, cs_n}), 64'b00_11);

    // Reset mid-frame abandons the frame with no done pulse
    start_frame({8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77}, 1'b1, t0);
    repeat (50) @(negedge clk);
    chk("busy_mid_frame", 64'(busy), 64'b11);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("midframe_reset_outputs_%0d", d),
          64'({busy[d], done[d], sclk[d], mosi[d], cs_n[d]}), 64'b00001);
    base0 = done_n[0];
    base1 = done_n[1];
    reset = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    repeat (600) @(negedge clk);
    #1;
    chk("no_done_after_abort_a", 64'(done_n[0] - base0), 64'd0);
    chk("no_done_after_abort_b", 64'(done_n[1] - base1), 64'd0);
    chk("idle_after_abort", 64'({busy, sclk, cs_n}), 64'b00_00_11);

    // Table-driven frames on both instances
    for (int v = 0; v < 3; v++) begin
      rises[0] = 0;
      rises[1] = 0;
      base0 = done_n[0];
      base1 = done_n[1];
      start_frame(vecs[v].data, 1'b1, t0);
      if (vecs[v].poke) begin
        repeat (99) @(negedge clk);
        {lint, color_idx, red, green, blue, white, mode} = 56'hDEAD_BEEF_C0FFEE;
        start_a = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
      end
      wait_done(0, base0, t0, vecs[v].lat_a, $sformatf("vec%0d_a", v));
      wait_done(1, base1, t0, vecs[v].lat_b, $sformatf("vec%0d_b", v));
      repeat (20) @(negedge clk);
      #1;
      chk($sformatf("vec%0d_one_done_a", v), 64'(done_n[0] - base0), 64'd1);
      chk($sformatf("vec%0d_one_done_b", v), 64'(done_n[1] - base1), 64'd1);
      chk($sformatf("vec%0d_rises_a", v), 64'(rises[0]), 64'd64);
      chk($sformatf("vec%0d_rises_b", v), 64'(rises[1]), 64'd64);
      chk($sformatf("vec%0d_queues_empty", v), 64'(exp_q0.size() + exp_q1.size()), 64'd0);
      chk($sformatf("vec%0d_idle", v), 64'({busy, cs_n}), 64'b00_11);
    end

    // Back-to-back: start held high, next frame accepted in the done cycle
    rises[0] = 0;
    base0 = done_n[0];
    @(negedge clk);
    {lint, color_idx, red, green, blue, white, mode} = vecs[2].data;
    push_frame(0, vecs[2].data);
    push_frame(0, vecs[2].data);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    wait_done(0, base0, t0, 544, "b2b_first");
    chk("b2b_cs_high_in_done", 64'(cs_n[0]), 64'd1);
    chk("b2b_busy_low_in_done", 64'(busy[0]), 64'd0);
    t1 = done_cyc[0] + 1;
    @(negedge clk);
    chk("b2b_cs_low_again", 64'(cs_n[0]), 64'd0);
    chk("b2b_busy_again", 64'(busy[0]), 64'd1);
    start_a = 1'b0;
    wait_done(0, base0 + 1, t1, 544, "b2b_second");
    repeat (5) @(negedge clk);
    #1;
    chk("b2b_rises", 64'(rises[0]), 64'd128);
    chk("b2b_queue_empty", 64'(exp_q0.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
